// File: rtl/clock_tree_monitor.sv
// Consumer side of the 5-bit clock-tree bus: turns the tick lines into qualified edge
// enables, measures the derived clock's phase widths and flags bus protocol faults.
module clock_tree_monitor #(
  parameter int counterBits   = 24,
  parameter int timeoutCycles = 2000000
) (
  input  logic                   globalClock,
  input  logic                   resetN,
  input  logic [4:0]             clockBus,
  input  logic                   clearFaults,
  output logic                   posEdge,
  output logic                   negEdge,
  output logic [counterBits-1:0] highWidth,
  output logic [counterBits-1:0] lowWidth,
  output logic                   widthValid,
  output logic                   locked,
  output logic [2:0]             faultFlags
);

  localparam int IdleW = $clog2(timeoutCycles + 1);
  localparam logic [IdleW-1:0]       IdleMax  = IdleW'(timeoutCycles);
  localparam logic [IdleW-1:0]       IdleLast = IdleW'(timeoutCycles - 1);
  localparam logic [counterBits-1:0] CntMax   = '1;

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  function automatic logic [counterBits-1:0] sat_inc(input logic [counterBits-1:0] v);
    return (v == CntMax) ? v : v + 1'b1;
  endfunction

  state_t r_state;
  state_t w_stateNext;

  logic w_lvl, w_cmpl, w_pt, w_nt, w_tick, w_unusedGclk;
  logic w_cmpFault, w_seqFault, w_toFault, w_fault;
  logic w_pe, w_ne, w_capHigh, w_capLow;
  logic w_gotHighNext, w_gotLowNext, w_lockedNext;
  logic [2:0]             w_newFaults, w_flagsNext;
  logic [counterBits-1:0] w_widthNow, w_phaseNext;
  logic [IdleW-1:0]       w_idleNext;

  logic                   r_prevLvl, r_prevTick, r_histValid;
  logic                   r_gotHigh, r_gotLow;
  logic [counterBits-1:0] r_phaseCnt;
  logic [IdleW-1:0]       r_idleCnt;
  logic                   r_posEdge, r_negEdge, r_widthValid, r_locked;
  logic [counterBits-1:0] r_highWidth, r_lowWidth;
  logic [2:0]             r_faultFlags;

  // Bit 4 is the generator's copy of globalClock; this block already runs on it.
  assign w_unusedGclk = clockBus[4];
  assign w_lvl  = clockBus[0];
  assign w_cmpl = clockBus[1];
  assign w_pt   = clockBus[2];
  assign w_nt   = clockBus[3];
  assign w_tick = w_pt | w_nt;

  assign w_cmpFault = (w_cmpl == w_lvl);
  // A tick is issued while bit0 still shows the old level, so the level must flip next cycle.
  assign w_seqFault = (w_pt & w_nt)
                    | (w_pt & w_lvl) | (w_nt & ~w_lvl)
                    | ((r_state == HIGH) & w_pt) | ((r_state == LOW) & w_nt)
                    | (r_histValid & (w_lvl != r_prevLvl) & ~r_prevTick);
  assign w_toFault  = ~w_tick & (r_idleCnt == IdleLast);
  assign w_newFaults = {w_toFault, w_seqFault, w_cmpFault};
  assign w_fault     = |w_newFaults;

  always_ff @(posedge globalClock) begin
    if (!resetN) r_state <= SYNC;
    else         r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    w_pe        = 1'b0;
    w_ne        = 1'b0;
    w_capHigh   = 1'b0;
    w_capLow    = 1'b0;
    if (w_fault) begin
      w_stateNext = SYNC;
    end else begin
      case (r_state)
        SYNC: begin
          if (w_pt) begin
            w_stateNext = HIGH;
            w_pe        = 1'b1;
          end else if (w_nt) begin
            w_stateNext = LOW;
            w_ne        = 1'b1;
          end
        end
        HIGH: begin
          if (w_nt) begin
            w_stateNext = LOW;
            w_ne        = 1'b1;
            w_capHigh   = 1'b1;
          end
        end
        LOW: begin
          if (w_pt) begin
            w_stateNext = HIGH;
            w_pe        = 1'b1;
            w_capLow    = 1'b1;
          end
        end
        default: w_stateNext = SYNC;
      endcase
    end
  end

  // The closing tick cycle itself is part of the phase, hence the +1 at capture.
  assign w_widthNow  = sat_inc(r_phaseCnt);
  assign w_phaseNext = (w_pe | w_ne | w_fault) ? '0 : w_widthNow;
  assign w_idleNext  = w_tick ? '0 : ((r_idleCnt == IdleMax) ? IdleMax : r_idleCnt + 1'b1);

  assign w_gotHighNext = ~w_fault & (r_gotHigh | w_capHigh);
  assign w_gotLowNext  = ~w_fault & (r_gotLow | w_capLow);
  assign w_lockedNext  = ~w_fault & (r_locked | (w_gotHighNext & w_gotLowNext));
  assign w_flagsNext   = (clearFaults ? 3'b000 : r_faultFlags) | w_newFaults;

  always_ff @(posedge globalClock) begin
    r_prevLvl  <= w_lvl;
    r_prevTick <= w_tick;
  end

  always_ff @(posedge globalClock) begin
    if (!resetN) begin
      r_histValid  <= 1'b0;
      r_phaseCnt   <= '0;
      r_idleCnt    <= '0;
      r_gotHigh    <= 1'b0;
      r_gotLow     <= 1'b0;
      r_posEdge    <= 1'b0;
      r_negEdge    <= 1'b0;
      r_widthValid <= 1'b0;
      r_locked     <= 1'b0;
      r_highWidth  <= '0;
      r_lowWidth   <= '0;
      r_faultFlags <= 3'b000;
    end else begin
      r_histValid  <= 1'b1;
      r_phaseCnt   <= w_phaseNext;
      r_idleCnt    <= w_idleNext;
      r_gotHigh    <= w_gotHighNext;
      r_gotLow     <= w_gotLowNext;
      r_posEdge    <= w_pe;
      r_negEdge    <= w_ne;
      r_widthValid <= w_capHigh | w_capLow;
      r_locked     <= w_lockedNext;
      r_faultFlags <= w_flagsNext;
      if (w_capHigh) r_highWidth <= w_widthNow;
      if (w_capLow)  r_lowWidth  <= w_widthNow;
    end
  end

  assign posEdge    = r_posEdge;
  assign negEdge    = r_negEdge;
  assign highWidth  = r_highWidth;
  assign lowWidth   = r_lowWidth;
  assign widthValid = r_widthValid;
  assign locked     = r_locked;
  assign faultFlags = r_faultFlags;

endmodule

// File: tb/tb_clock_tree_monitor.sv
// Directed bench for clock_tree_monitor: expected edge/width events go into a queue,
// a negedge monitor pops and compares them; flags and lock are checked inline.
module tb_clock_tree_monitor;

  logic       clk = 1'b0;
  logic       resetN, clearFaults;
  logic [4:0] clockBus;
  logic       posEdge, negEdge, widthValid, locked;
  logic [7:0] highWidth, lowWidth;
  logic [2:0] faultFlags;

  logic       resetN_b;
  logic [4:0] clockBus_b;
  logic       posEdge_b, negEdge_b, widthValid_b, locked_b;
  logic [3:0] highWidth_b, lowWidth_b;
  logic [2:0] faultFlags_b;

  int  n_tests = 0;
  int  n_fail  = 0;
  int  cyc_cnt = 0;
  bit  lvl  = 1'b0;
  bit  lvlB = 1'b0;

  typedef struct {
    int       cyc;
    bit       pe, ne, wv;
    int       hw, lw;
    bit       lk;
    bit [2:0] ff;
  } ev_t;
  ev_t exp_q[$];
  ev_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt++;

  clock_tree_monitor #(.counterBits(8), .timeoutCycles(16)) dut (
    .globalClock(clk), .resetN(resetN), .clockBus(clockBus), .clearFaults(clearFaults),
    .posEdge(posEdge), .negEdge(negEdge), .highWidth(highWidth), .lowWidth(lowWidth),
    .widthValid(widthValid), .locked(locked), .faultFlags(faultFlags)
  );

  clock_tree_monitor #(.counterBits(4), .timeoutCycles(100)) dut_b (
    .globalClock(clk), .resetN(resetN_b), .clockBus(clockBus_b), .clearFaults(1'b0),
    .posEdge(posEdge_b), .negEdge(negEdge_b), .highWidth(highWidth_b), .lowWidth(lowWidth_b),
    .widthValid(widthValid_b), .locked(locked_b), .faultFlags(faultFlags_b)
  );

  // Scoreboard monitor: every edge/width pulse must match the next queued event.
  always @(negedge clk) begin
    if (posEdge || negEdge || widthValid) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event cyc=%0d actual pe=%0b ne=%0b wv=%0b hw=%0d lw=%0d lk=%0b ff=%b required no event",
                 cyc_cnt, posEdge, negEdge, widthValid, highWidth, lowWidth, locked, faultFlags);
      end else begin
        mon_e = exp_q.pop_front();
        if (cyc_cnt != mon_e.cyc || posEdge != mon_e.pe || negEdge != mon_e.ne ||
            widthValid != mon_e.wv || int'(highWidth) != mon_e.hw || int'(lowWidth) != mon_e.lw ||
            locked != mon_e.lk || faultFlags != mon_e.ff) begin
          n_fail++;
          $display("FAIL event actual cyc=%0d pe=%0b ne=%0b wv=%0b hw=%0d lw=%0d lk=%0b ff=%b required cyc=%0d pe=%0b ne=%0b wv=%0b hw=%0d lw=%0d lk=%0b ff=%b",
                   cyc_cnt, posEdge, negEdge, widthValid, highWidth, lowWidth, locked, faultFlags,
                   mon_e.cyc, mon_e.pe, mon_e.ne, mon_e.wv, mon_e.hw, mon_e.lw, mon_e.lk, mon_e.ff);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // One bus cycle on dut; bad=1 breaks the complement line for that cycle.
  task automatic cyc(input bit pt, input bit nt, input bit bad);
    clockBus = {1'b0, nt, pt, (bad ? lvl : ~lvl), lvl};
    @(posedge clk); #1;
    if (pt && !nt) lvl = 1'b1;
    else if (nt && !pt) lvl = 1'b0;
    clockBus = {1'b0, 1'b0, 1'b0, ~lvl, lvl};
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic tk(input bit pt, input bit nt, input bit pe, input bit ne, input bit wv,
                    input int hw, input int lw, input bit lk, input bit [2:0] ff);
    ev_t e;
    e.cyc = cyc_cnt + 1; e.pe = pe; e.ne = ne; e.wv = wv;
    e.hw = hw; e.lw = lw; e.lk = lk; e.ff = ff;
    exp_q.push_back(e);
    cyc(pt, nt, 1'b0);
  endtask

  task automatic cycB(input bit pt, input bit nt);
    clockBus_b = {1'b0, nt, pt, ~lvlB, lvlB};
    @(posedge clk); #1;
    if (pt) lvlB = 1'b1;
    if (nt) lvlB = 1'b0;
    clockBus_b = {1'b0, 1'b0, 1'b0, ~lvlB, lvlB};
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_posEdge"}, posEdge, 0);
    chk({tag, "_negEdge"}, negEdge, 0);
    chk({tag, "_highWidth"}, highWidth, 0);
    chk({tag, "_lowWidth"}, lowWidth, 0);
    chk({tag, "_widthValid"}, widthValid, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_faultFlags"}, faultFlags, 0);
  endtask

  initial begin
    resetN = 1'b0; clearFaults = 1'b0;
    clockBus = 5'b00010;
    resetN_b = 1'b0; clockBus_b = 5'b00010;
    @(posedge clk); #1;
    idle(3);
    chk_all_zero("reset");
    resetN = 1'b1;

    // Ticks every 4 cycles
    idle(2);
    tk(1, 0, 1, 0, 0, 0, 0, 0, 3'b000);
    idle(3);
    tk(0, 1, 0, 1, 1, 4, 0, 0, 3'b000);
    idle(3);
    tk(1, 0, 1, 0, 1, 4, 4, 1, 3'b000);
    idle(3);
    tk(0, 1, 0, 1, 1, 4, 4, 1, 3'b000);
    chk("t1_flags", faultFlags, 0);
    chk("t1_locked", locked, 1);

    // Tick every cycle
    tk(1, 0, 1, 0, 1, 4, 1, 1, 3'b000);
    tk(0, 1, 0, 1, 1, 1, 1, 1, 3'b000);
    tk(1, 0, 1, 0, 1, 1, 1, 1, 3'b000);
    tk(0, 1, 0, 1, 1, 1, 1, 1, 3'b000);

    // Complement fault while locked
    cyc(0, 0, 1);
    chk("cmp_flags", faultFlags, 3'b001);
    chk("cmp_locked", locked, 0);
    clearFaults = 1'b1; cyc(0, 0, 0); clearFaults = 1'b0;
    chk("cmp_cleared", faultFlags, 0);
    tk(1, 0, 1, 0, 0, 1, 1, 0, 3'b000);
    idle(1);
    tk(0, 1, 0, 1, 1, 2, 1, 0, 3'b000);
    idle(1);
    tk(1, 0, 1, 0, 1, 2, 2, 1, 3'b000);

    // Both ticks together (currently HIGH)
    cyc(1, 1, 0);
    chk("dual_flags", faultFlags, 3'b010);
    chk("dual_locked", locked, 0);
    tk(0, 1, 0, 1, 0, 2, 2, 0, 3'b010);
    idle(1);
    tk(1, 0, 1, 0, 1, 2, 2, 0, 3'b010);
    clearFaults = 1'b1; cyc(0, 0, 0); clearFaults = 1'b0;
    tk(0, 1, 0, 1, 1, 2, 2, 1, 3'b000);

    // posTick while in HIGH
    idle(1);
    tk(1, 0, 1, 0, 1, 2, 2, 1, 3'b000);
    cyc(1, 0, 0);
    chk("seq_flags", faultFlags, 3'b010);
    chk("seq_locked", locked, 0);
    chk("seq_no_pos", posEdge, 0);
    tk(0, 1, 0, 1, 0, 2, 2, 0, 3'b010);
    idle(1);
    tk(1, 0, 1, 0, 1, 2, 2, 0, 3'b010);
    clearFaults = 1'b1; cyc(0, 0, 0); clearFaults = 1'b0;
    tk(0, 1, 0, 1, 1, 2, 2, 1, 3'b000);

    // Timeout at the 16th idle cycle
    idle(15);
    chk("to_before_flags", faultFlags, 0);
    chk("to_before_locked", locked, 1);
    idle(1);
    chk("to_flags", faultFlags, 3'b100);
    chk("to_locked", locked, 0);
    idle(5);
    chk("to_sticky", faultFlags, 3'b100);
    clearFaults = 1'b1; cyc(0, 0, 0); clearFaults = 1'b0;
    idle(20);
    chk("to_once", faultFlags, 0);
    tk(1, 0, 1, 0, 0, 2, 2, 0, 3'b000);
    idle(1);
    tk(0, 1, 0, 1, 1, 2, 2, 0, 3'b000);
    idle(1);
    tk(1, 0, 1, 0, 1, 2, 2, 1, 3'b000);
    chk("to_relock", locked, 1);

    // Reset in the middle of a HIGH phase
    idle(2);
    resetN = 1'b0; cyc(0, 0, 0); resetN = 1'b1;
    chk_all_zero("midreset");
    idle(1);
    tk(0, 1, 0, 1, 0, 0, 0, 0, 3'b000);
    idle(2);
    tk(1, 0, 1, 0, 1, 0, 3, 0, 3'b000);
    idle(3);
    chk("queue_empty", exp_q.size(), 0);

    // Saturation on the 4-bit instance: 20-cycle high phase
    resetN_b = 1'b1;
    cycB(0, 0); cycB(0, 0);
    cycB(1, 0);
    chk("sat_exit_pos", posEdge_b, 1);
    for (int i = 0; i < 19; i++) cycB(0, 0);
    cycB(0, 1);
    chk("sat_wv", widthValid_b, 1);
    chk("sat_neg", negEdge_b, 1);
    chk("sat_highWidth", highWidth_b, 15);
    cycB(0, 0); cycB(0, 0);
    cycB(1, 0);
    chk("sat_lowWidth", lowWidth_b, 3);
    chk("sat_locked", locked_b, 1);
    chk("sat_flags", faultFlags_b, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
